// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the control decoder: state
// encoding, halt opcode, instruction field positions and the per-program
// branch-target table.
package fetch_unit_pkg;

  localparam int PC_W   = 10;
  localparam int INST_W = 9;
  localparam int KEY_W  = 5;

  localparam logic [INST_W-1:0] HALT_INST = 9'h1FF;

  // Instruction field positions: branch flag, opcode, branch key
  localparam int OP_BR_BIT = 8;
  localparam int OP_HI     = 7;
  localparam int OP_LO     = 5;
  localparam int KEY_HI    = 4;
  localparam int KEY_LO    = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Branch-target table of the current program; unlisted keys map to 0
  function automatic logic [PC_W-1:0] program_target(input logic [KEY_W-1:0] key);
    logic [PC_W-1:0] tgt;
    tgt = '0;
    case (key)
      5'd3:    tgt = 10'd40;
      5'd7:    tgt = 10'd100;
      5'd12:   tgt = 10'h3FF;
      5'd31:   tgt = 10'd512;
      default: tgt = '0;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Constant key-to-target ROM used for taken branches. Pure combinational;
// reset has no effect on its contents.
module branch_lut #(
  parameter int PC_W      = fetch_unit_pkg::PC_W,
  parameter int LUT_DEPTH = 32
) (
  input  logic [fetch_unit_pkg::KEY_W-1:0] key,
  output logic [PC_W-1:0]                  target
);
  import fetch_unit_pkg::*;

  logic [PC_W-1:0] rom [LUT_DEPTH];

  // Populate every ROM entry from the program table
  for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_rom
    assign rom[i] = PC_W'(program_target(KEY_W'(i)));
  end

  assign target = rom[key];

endmodule

// File: rtl/fetch_unit.sv
// Program fetch sequencer: IDLE -> RUN -> DONE FSM driving the PC register.
// Branch targets come from the branch_lut ROM; halt beats a taken branch.
module fetch_unit #(
  parameter int                  PC_W      = fetch_unit_pkg::PC_W,
  parameter int                  LUT_DEPTH = 32,
  parameter logic [8:0]          HALT_INST = fetch_unit_pkg::HALT_INST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  input  logic            stall,
  input  logic [8:0]      inst,
  input  logic            branch_en,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            fetch_en,
  output logic            done
);
  import fetch_unit_pkg::*;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] branch_target;

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_DEPTH (LUT_DEPTH)
  ) u_branch_lut (
    .key    (inst[KEY_HI:KEY_LO]),
    .target (branch_target)
  );

  // State and PC registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Next-state and next-PC selection
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          pc_nxt    = start_addr;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          if (inst == HALT_INST) begin
            state_nxt = DONE;
          end else if (branch_en) begin
            pc_nxt = branch_target;
          end else begin
            pc_nxt = pc + PC_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign running  = (state == RUN);
  assign done     = (state == DONE);
  assign fetch_en = running & ~stall;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 10, program-counter width (1024-word instruction space).
REQ-002 Parameter LUT_DEPTH, default 32, branch-target table entries, indexed by the 5-bit branch key.
REQ-003 Parameter HALT_INST, default 9'h1FF, instruction encoding that ends a program.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high. Ports: clk and reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  level request to begin a program; sampled only in IDLE or DONE.
REQ-008 start_addr  input  PC_W  first PC of the program; captured with start.
REQ-009 stall  input  1  hold PC for this cycle; inst is not valid.
REQ-010 inst  input  9  current instruction word at address pc, from the instruction ROM.
REQ-011 branch_en  input  1  taken-branch decision from the control decoder for inst.
REQ-012 pc  output  PC_W  registered fetch address.
REQ-013 running  output  1  high while in RUN.
REQ-014 fetch_en  output  1  running & ~stall; the inst/branch_en pair is consumed this cycle.
REQ-015 done  output  1  high while in DONE.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; running and done SHALL decode directly from state.
REQ-017 IDLE, start=1: pc<=start_addr, next state RUN; start=0: hold.
REQ-018 RUN, stall=1: pc and state SHALL hold; inst, branch_en and halt detection are ignored.
REQ-019 RUN, stall=0, inst==HALT_INST: pc holds, next state DONE; halt takes priority over branch_en.
REQ-020 RUN, stall=0, branch_en=1, not halt: pc<=lut[inst[4:0]] (absolute target, PC_W bits).
REQ-021 RUN, stall=0, otherwise: pc<=pc+1 modulo 2^PC_W; 2^PC_W-1 wraps to 0 without a flag.
REQ-022 Latency: the new pc SHALL be visible the cycle after the decision edge; no delay slot.
REQ-023 start in RUN SHALL be ignored.
REQ-024 DONE, start=1: pc<=start_addr, next state RUN, with done low from that edge; start=0: hold, with pc frozen at the halt address.
REQ-025 A start that is held continuously SHALL relaunch the program one cycle after each DONE entry; this is intended, and callers drop start to avoid it.
REQ-026 Branch-key bits inst[4:0] SHALL index the LUT only when inst[8]=1; pc SHALL depend on branch_en alone, not on decoding inst here.

Reset
REQ-027 Reset SHALL set state IDLE, pc=0, running=0, done=0, fetch_en=0 on the next clk edge.
REQ-028 Reset SHALL override start, stall and a halt in the same cycle.
REQ-029 Reset mid-RUN SHALL abandon the program; no done pulse is produced.
REQ-030 The LUT is constant, and reset SHALL NOT affect it.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the HALT_INST constant, the opcode field positions (inst[8], inst[7:5], inst[4:0]) and PC_W. The control decoder reuses them.
REQ-032 One sub-module, branch_lut, SHALL hold the combinational key-to-target ROM (LUT_DEPTH x PC_W). It is initialised from a per-program table, with unlisted entries set to 0.
REQ-033 fetch_unit SHALL contain the FSM, the PC register and the next-PC mux only; no memory-array access.

Verification
REQ-034 Reset, then start=1 with start_addr=10'd5 for one cycle, non-branch inst -> pc 5,6,7 on successive edges; running=1.
REQ-035 Program lut[3]=10'd40; at pc=7 drive inst=9'h103 with branch_en=1 -> pc=40 next cycle; with branch_en=0 -> pc=8.
REQ-036 stall=1 for 3 cycles at pc=12 with branch_en=1 -> pc stays 12 and fetch_en=0; after release, pc=13.
REQ-037 At pc=20 drive inst=9'h1FF with branch_en=1 -> DONE, pc stays 20, done=1; then start=1 with start_addr=0 -> pc=0, done=0.
REQ-038 From start_addr=10'h3FE with non-branch inst -> pc 3FE, 3FF, 000.
REQ-039 reset=1 in RUN at pc=9 while inst=HALT_INST -> IDLE, pc=0, done=0, no DONE entry.
